// File: rtl/cpu_state_dump_pkg.sv
// Shared types and constants for the CPU state-dump debug block.
// Optional header build: define CPU_STATE_DUMP_HEADER_EN.
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_REGS = 3'd2,
      ST_DMEM = 3'd3,
      ST_FIN  = 3'd4
   } dump_state_t;

   localparam int HDR_WORDS   = 2;
   localparam int HDR_IDX_CYC = 0;
   localparam int HDR_IDX_PC  = 1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cpu_state_dump_if.sv
// Valid/ready stream carrying dumped words to the consumer.
// Master drives the word, slave returns ready.
interface cpu_state_dump_if #(
   parameter int DATA_W = 32
);
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;

   modport master (
      output dump_valid,
      output dump_data,
      output dump_last,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_data,
      input  dump_last,
      output dump_ready
   );
endinterface

// File: rtl/cpu_state_dump_out_reg.sv
// Single-entry valid/ready holding register for the dump stream.
// Loads when empty or when the held word is being accepted.
module dump_out_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load_req,
   input  logic [DATA_W-1:0] i_load_data,
   input  logic              i_load_last,
   output logic              o_load,
   output logic              o_xfer,
   cpu_state_dump_if.master  m_dump
);

   logic              r_valid;
   logic              r_last;
   logic [DATA_W-1:0] r_data;
   logic              w_free;

   assign w_free = !r_valid || m_dump.dump_ready;
   assign o_load = i_load_req && w_free;
   assign o_xfer = r_valid && m_dump.dump_ready;

   // Hold the word while stalled; refill or drain when the slot frees
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else if (w_free) begin
         r_valid <= i_load_req;
         r_last  <= i_load_req && i_load_last;
         if (i_load_req) begin
            r_data <= i_load_data;
         end
      end
   end

   assign m_dump.dump_valid = r_valid;
   assign m_dump.dump_data  = r_data;
   assign m_dump.dump_last  = r_last;

endmodule

// File: rtl/cpu_state_dump.sv
// Freezes the CPU and streams header, register file and low DM words.
// Define CPU_STATE_DUMP_HEADER_EN to prefix cycle-count and PC words.
module cpu_state_dump
   import cpu_dbg_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int NUM_DM_WORDS = 16,
   parameter int DATA_W       = 32,
   parameter int DM_ADDR_W    = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [31:0]          i_pc,
   output logic [4:0]           o_reg_raddr,
   input  logic [DATA_W-1:0]    i_reg_rdata,
   output logic [DM_ADDR_W-1:0] o_dm_raddr,
   input  logic [DATA_W-1:0]    i_dm_rdata,
   output logic                 o_cpu_stall,
   output logic                 o_busy,
   output logic                 o_done,
   cpu_state_dump_if.master     m_dump
);

   localparam int IDX_W =
      $clog2(max2(max2(NUM_REGS, NUM_DM_WORDS), HDR_WORDS) + 1);
   localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] DM_END   = IDX_W'(NUM_DM_WORDS);
   localparam logic [IDX_W-1:0] DM_LAST  = IDX_W'(NUM_DM_WORDS - 1);

   dump_state_t       r_state;
   logic [IDX_W-1:0]  r_idx;
   logic              r_busy;
   logic              r_stall;
   logic              r_done;

   logic              w_load_req;
   logic [DATA_W-1:0] w_load_data;
   logic              w_load_last;
   logic              w_load;
   logic              w_xfer;

`ifdef CPU_STATE_DUMP_HEADER_EN
   logic [31:0] r_cyc;
   logic [31:0] r_hdr_cyc;

   // Free-running cycle counter, wraps at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cyc <= '0;
      end else begin
         r_cyc <= r_cyc + 32'd1;
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^i_pc;
`endif

   // Select the next word to offer to the holding register
   always_comb begin
      w_load_req  = 1'b0;
      w_load_data = '0;
      w_load_last = 1'b0;
      unique case (r_state)
`ifdef CPU_STATE_DUMP_HEADER_EN
         ST_HDR: begin
            w_load_req  = 1'b1;
            w_load_data = (r_idx == IDX_W'(HDR_IDX_CYC))
                        ? DATA_W'(r_hdr_cyc)
                        : DATA_W'(i_pc);
         end
`endif
         ST_REGS: begin
            w_load_req  = 1'b1;
            w_load_data = i_reg_rdata;
         end
         ST_DMEM: begin
            w_load_req  = (r_idx < DM_END);
            w_load_data = i_dm_rdata;
            w_load_last = (r_idx == DM_LAST);
         end
         default: ;
      endcase
   end

   assign o_reg_raddr = (r_state == ST_REGS) ? 5'(r_idx) : 5'd0;
   assign o_dm_raddr  = (r_state == ST_DMEM) ? DM_ADDR_W'(r_idx)
                                             : '0;

   // Dump sequencer: index walk, stall/busy control, done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_stall <= 1'b0;
         r_done  <= 1'b0;
`ifdef CPU_STATE_DUMP_HEADER_EN
         r_hdr_cyc <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_stall <= 1'b1;
`ifdef CPU_STATE_DUMP_HEADER_EN
                  r_state   <= ST_HDR;
                  r_hdr_cyc <= r_cyc;
`else
                  r_state <= ST_REGS;
`endif
               end
            end
`ifdef CPU_STATE_DUMP_HEADER_EN
            ST_HDR: begin
               if (w_load) begin
                  if (r_idx == IDX_W'(HDR_WORDS - 1)) begin
                     r_state <= ST_REGS;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
`endif
            ST_REGS: begin
               if (w_load) begin
                  if (r_idx == REG_LAST) begin
                     r_state <= ST_DMEM;
                     r_idx   <= '0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_DMEM: begin
               if (w_load) begin
                  r_idx <= r_idx + 1'b1;
               end else if (r_idx == DM_END && w_xfer) begin
                  r_state <= ST_FIN;
                  r_busy  <= 1'b0;
                  r_stall <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_cpu_stall = r_stall;
   assign o_done      = r_done;

   dump_out_reg #(
      .DATA_W (DATA_W)
   ) u_out (
      .clk         (clk),
      .rst         (rst),
      .i_load_req  (w_load_req),
      .i_load_data (w_load_data),
      .i_load_last (w_load_last),
      .o_load      (w_load),
      .o_xfer      (w_xfer),
      .m_dump      (m_dump)
   );

endmodule

// File: tb/tb_cpu_state_dump.sv
// Directed bench for cpu_state_dump: plain, back-pressure, held start,
// mid-dump reset and restart; works with or without the header build.
module tb_cpu_state_dump;
   import cpu_dbg_pkg::*;

   localparam int NR = 32;
   localparam int ND = 16;
`ifdef CPU_STATE_DUMP_HEADER_EN
   localparam int HW = HDR_WORDS;
`else
   localparam int HW = 0;
`endif
   localparam int NW = HW + NR + ND;
   localparam logic [31:0] WB4 = 32'hFFFF_FFF6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] pc;
   logic [31:0] cyc;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic [6:0]  dm_raddr;
   logic [31:0] dm_rdata;
   logic        cpu_stall;
   logic        busy;
   logic        done;
   logic        wb_pend = 1'b0;
   logic        wb_done = 1'b0;

   logic [31:0] regs  [32];
   logic [31:0] dm    [128];
   logic [31:0] exp_w [NW];

   int errors = 0;
   int checks = 0;

   cpu_state_dump_if #(.DATA_W(32)) u_if ();

   cpu_state_dump u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_pc        (pc),
      .o_reg_raddr (reg_raddr),
      .i_reg_rdata (reg_rdata),
      .o_dm_raddr  (dm_raddr),
      .i_dm_rdata  (dm_rdata),
      .o_cpu_stall (cpu_stall),
      .o_busy      (busy),
      .o_done      (done),
      .m_dump      (u_if)
   );

   always #5 clk = ~clk;

   // Simple CPU stand-in: PC advances unless stalled
   always_ff @(posedge clk) begin
      if (rst) pc <= 32'h0040_0040;
      else if (!cpu_stall) pc <= pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) cyc <= '0;
      else cyc <= cyc + 32'd1;
   end

   // In-flight sub $4 retires only when the pipeline is not frozen
   always_ff @(posedge clk) begin
      if (wb_pend && !cpu_stall) wb_done <= 1'b1;
   end

   always_comb begin
      reg_rdata = regs[reg_raddr];
      if (wb_done && reg_raddr == 5'd4) reg_rdata = WB4;
      dm_rdata = dm[dm_raddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_dump(input string tag, input bit toggle,
                           input bit hold_start, input int stop_at,
                           input bit with_wb);
      int n;
      int g;
      int first_g;
      bit held_v;
      bit moved;
      logic [31:0] held_d;
      logic [31:0] pc0;
      n = 0; g = 0; first_g = -1;
      held_v = 0; moved = 0; held_d = '0;
      u_if.dump_ready = 1'b1;
      start = 1'b1;
`ifdef CPU_STATE_DUMP_HEADER_EN
      exp_w[HDR_IDX_CYC] = cyc;
`endif
      tick();
      if (!hold_start) start = 1'b0;
      if (with_wb) wb_pend = 1'b1;
      pc0 = pc;
`ifdef CPU_STATE_DUMP_HEADER_EN
      exp_w[HDR_IDX_PC] = pc;
`endif
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_stall0"}, cpu_stall, 1);
      chk({tag, "_valid0"}, u_if.dump_valid, 0);
      while (n < stop_at && g < 400) begin
         tick();
         g++;
         if (pc !== pc0) moved = 1;
         if (toggle) u_if.dump_ready = ~u_if.dump_ready;
         if (held_v) begin
            chk({tag, "_hold_v"}, u_if.dump_valid, 1);
            chk({tag, "_hold_d"}, u_if.dump_data, held_d);
         end
         held_v = 0;
         if (u_if.dump_valid) begin
            if (first_g < 0) first_g = g;
            if (u_if.dump_ready) begin
               chk($sformatf("%s_w%0d", tag, n), u_if.dump_data, exp_w[n]);
               chk($sformatf("%s_last%0d", tag, n), u_if.dump_last,
                   (n == NW - 1) ? 1 : 0);
               n++;
            end else begin
               held_v = 1;
               held_d = u_if.dump_data;
            end
         end
      end
      chk({tag, "_count"}, n, stop_at);
      chk({tag, "_pc_frozen"}, moved, 0);
      if (stop_at == NW && n == NW) begin
         chk({tag, "_cycles"}, g + 1 - first_g, toggle ? 2 * NW : NW);
         tick();
         chk({tag, "_done"}, done, 1);
         chk({tag, "_fin_busy"}, busy, 0);
         chk({tag, "_fin_stall"}, cpu_stall, 0);
         chk({tag, "_fin_valid"}, u_if.dump_valid, 0);
         start = 1'b0;
         tick();
         chk({tag, "_done_pulse"}, done, 0);
         chk({tag, "_idle_busy"}, busy, 0);
         tick();
         chk({tag, "_still_idle"}, busy, 0);
      end
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      for (int i = 0; i < 128; i++) dm[i] = '0;
      regs[1] = 32'd25; regs[2] = 32'd25; regs[3] = 32'd50;
      regs[5] = 32'd25; regs[6] = 32'd25; regs[8] = 32'd31;
      dm[0] = 32'd9; dm[1] = 32'd3;
      for (int i = 0; i < NW; i++) exp_w[i] = '0;
      exp_w[HW + 1] = 32'h19; exp_w[HW + 2] = 32'h19;
      exp_w[HW + 3] = 32'h32; exp_w[HW + 5] = 32'h19;
      exp_w[HW + 6] = 32'h19; exp_w[HW + 8] = 32'h1F;
      exp_w[HW + NR] = 32'd9; exp_w[HW + NR + 1] = 32'd3;
      u_if.dump_ready = 1'b1;

      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", u_if.dump_valid, 0);
      chk("rst_last", u_if.dump_last, 0);
      chk("rst_data", u_if.dump_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_done", done, 0);
      chk("rst_raddr", reg_raddr, 0);
      chk("rst_dmaddr", dm_raddr, 0);

      guard = 0;
      while (cyc != 32'd40 && guard < 100) begin
         tick();
         guard++;
      end
      chk("cyc40", cyc, 40);

      run_dump("plain", 1'b0, 1'b0, NW, 1'b0);
      run_dump("bp", 1'b1, 1'b0, NW, 1'b1);
      wb_pend = 1'b0;
      chk("wb_retired", wb_done, 1);
      exp_w[HW + 4] = WB4;
      run_dump("hold", 1'b0, 1'b1, NW, 1'b0);

      run_dump("rst", 1'b0, 1'b0, 20, 1'b0);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", u_if.dump_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_stall", cpu_stall, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_data", u_if.dump_data, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);
      run_dump("again", 1'b0, 1'b0, NW, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_state_dump.md
# cpu_state_dump

Read-side debug block for the pipelined MIPS CPU: on request, it freezes the pipeline, walks the register file and the low data-memory window in order, and streams every word out on a valid/ready interface. It sits beside `CPU`, tapping the ID-stage register-file read port and the MEM-stage data-memory read port. The dumped state is the same architectural state the simulation bench prints each cycle, so silicon and FPGA builds can be checked without hierarchical access.

## Interface
- `NUM_REGS`, default 32: register-file words dumped, starting at index 0.
- `NUM_DM_WORDS`, default 16: data-memory words dumped, starting at word 0.
- `DATA_W`, default 32: word width.
- `DM_ADDR_W`, default 7: data-memory word-address width (128 words).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  dump request; sampled only in IDLE.
- `pc`  in  32  current fetch PC (`FD_PC`), used by the header.
- `reg_raddr`  out  5  register-file debug read address.
- `reg_rdata`  in  DATA_W  combinational read data for `reg_raddr`.
- `dm_raddr`  out  DM_ADDR_W  data-memory debug word address.
- `dm_rdata`  in  DATA_W  combinational read data for `dm_raddr`.
- `cpu_stall`  out  1  freezes PC and all pipeline registers while high.
- `dump_valid`  out  1  `dump_data` holds a word.
- `dump_ready`  in  1  the consumer accepts the word.
- `dump_data`  out  DATA_W  streamed word.
- `dump_last`  out  1  the current word is the final word of the dump.
- `busy`  out  1  a dump is in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, HDR (header only), REGS, DMEM, FIN.
- IDLE with `start`=1: go to HDR if the header is compiled in, otherwise REGS. Clear the index counter and assert `busy` and `cpu_stall`.
- Single output holding register. It loads whenever `dump_valid`=0 or (`dump_valid` & `dump_ready`). On each load the index advances.
- HDR emits two words:
  - word 0: the free-running cycle counter (32-bit; clears on `rst`, +1 every cycle, wraps at 2^32).
  - word 1: `pc`.
- REGS: `reg_raddr`=index and the word loaded is `reg_rdata`, for index 0..NUM_REGS-1. Register 0 is emitted as read (it reads 0).
- DMEM: `dm_raddr`=index and the word loaded is `dm_rdata`, for index 0..NUM_DM_WORDS-1.
- `dump_last`=1 with the final DMEM word.
- FIN is entered on the handshake of the last word. In FIN:
  - `done`=1 for one cycle;
  - `busy`, `cpu_stall` and `dump_valid` are 0;
  - the next state is IDLE.
- `start` while not in IDLE is ignored; it is not queued.
- `dump_ready` may be held low indefinitely. `dump_data` and `dump_last` stay stable while `dump_valid`=1 and `dump_ready`=0.
- `rst` mid-dump: the next cycle is IDLE, every output is at its reset value, and the partial dump is discarded.

## Timing
- Reset values: `dump_valid`=0, `dump_last`=0, `dump_data`=0, `busy`=0, `cpu_stall`=0, `done`=0, `reg_raddr`=0, `dm_raddr`=0, cycle counter=0.
- `start` sampled at edge E: `busy` and `cpu_stall` are high from E. The first word is loaded at E+1, so `dump_valid` rises after E+1.
- With `dump_ready` held at 1, one word is transferred per cycle:
  - total words = NUM_REGS+NUM_DM_WORDS (48), plus 2 with the header (50);
  - `done` rises one cycle after the last handshake.
- Because `cpu_stall` is asserted before the first read, the snapshot is coherent. No writeback occurs between the first word and the last.
- The stall releases in the same cycle that `done` pulses. The CPU resumes at the frozen PC.

## Configuration
- `CPU_STATE_DUMP_HEADER_EN` defined: the HDR state exists and each dump is prefixed with the cycle-count word and the PC word, 50 words by default.
- Macro undefined: HDR and the cycle counter are removed, and dumps start directly at register 0 with 48 words by default.

## Structure
- Shared package `cpu_dbg_pkg`:
  - state enum `dump_state_t`;
  - `HDR_WORDS`=2;
  - header word-index constants.
- Sub-module `dump_out_reg`: the valid/ready holding register, which performs the load/hold logic and outputs `dump_valid`, `dump_data` and `dump_last`.
- The FSM, index counter and cycle counter live in `cpu_state_dump`.

## Test plan
- Preload REG[1]=25, REG[2]=25, DM[0]=9, DM[1]=3, run the 35-instruction add/sub/and/or/slt/addi program, then pulse `start` with `dump_ready`=1. Words 0..8 of the register section must be:
  - 0, 0x19, 0x19, 0x32, 0, 0x19, 0x19, 0, 0x1F;
  - the DM section then starts with 9, 3, followed by zeros;
  - `dump_last` is on the 48th word and `done` follows one cycle later.
- Back-pressure: toggle `dump_ready` 1/0 every cycle. All 48 words must arrive in order, with `dump_data` stable across stalled cycles and 96 cycles from the first valid to the last handshake.
- Stall coherency: with a `sub $4` in flight, issue `start`. PC must not change while `busy`=1, and R4 must read its pre-dump value.
- `start` held high for the whole dump: exactly one dump, with no second `busy` until `start` is sampled again in IDLE.
- `rst` at word 20 with `dump_ready`=1: the next cycle shows `dump_valid`=0, `busy`=0, `cpu_stall`=0; a new `start` restarts from REG[0].
- Header build: `start` at cycle counter 40 gives word 0=40 and word 1=current `pc`, with 50 words total.
